// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Cache data buses are byte-addressed with byte 0 in the MSB position.
package mem_stage_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [0:3] word_bytes_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_e;

   localparam logic [1:0] JUMP_LINK = 2'b10;

   // The timeout counter only has to reach n-1.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Store steering: computes the cache byte enables and write bytes for one access.
// A byte store lands on the lane selected by the address offset; other lanes are zero.
module mem_byte_lane
   import mem_stage_pkg::*;
(
   input  logic        is_byte,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic        is_write,
   output logic [0:3]  be,
   output word_bytes_t wdata
);

   always_comb begin
      be    = 4'b1111;
      wdata = '0;
      if (is_write) begin
         if (is_byte) begin
            be             = 4'b0000;
            be[offset]     = 1'b1;
            wdata[offset]  = store_data[7:0];
         end else begin
            wdata = store_data;
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one cache request per load/store, stalls
// upstream until the cache acknowledges, and registers the MEM/WB fields.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              in_valid,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_is_LB_SB,
   input  logic [ADDR_W-1:0] in_alu_result,
   input  logic [ADDR_W-1:0] in_store_data,
   input  logic              in_mem_to_reg,
   input  logic              in_reg_write,
   input  logic [1:0]        in_jump,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [4:0]        in_dest_reg,
   output logic              stall,
   output logic              cache_req,
   output logic              cache_we,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [0:3]        cache_be,
   output word_bytes_t       cache_wdata,
   input  logic              cache_ack,
   input  word_bytes_t       cache_rdata,
   output logic              wb_valid,
   output logic              wb_is_LB_SB,
   output logic              wb_mem_to_reg,
   output logic              wb_reg_write,
   output word_bytes_t       wb_cache_data_out,
   output logic [1:0]        wb_mem_block,
   output logic [1:0]        wb_jump,
   output logic [ADDR_W-1:0] wb_pc,
   output logic [ADDR_W-1:0] wb_alu_result,
   output logic [4:0]        wb_dest_reg,
   output logic              mem_error
);

   localparam int CNT_W = cnt_w(TIMEOUT_CYCLES);

   mem_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   word_bytes_t      r_rdata;

   logic        w_mem_op, w_misalign, w_start, w_access, w_timeout, w_wb_load;
   logic [0:3]  w_be;
   word_bytes_t w_wdata;

   assign w_mem_op   = in_valid & (in_mem_read | in_mem_write);
   assign w_misalign = ~in_is_LB_SB & (in_alu_result[1:0] != 2'b00);
   assign w_start    = (r_state == IDLE) & w_mem_op & ~w_misalign;
   assign w_access   = (r_state == ACCESS);
   assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_wb_load  = ((r_state == IDLE) & ~w_start) | (r_state == DONE);

   mem_byte_lane u_lane (
      .is_byte    (in_is_LB_SB),
      .offset     (in_alu_result[1:0]),
      .store_data (in_store_data[31:0]),
      .is_write   (in_mem_write),
      .be         (w_be),
      .wdata      (w_wdata)
   );

   // Requests are gated to ACCESS so the bus reads all-zero outside an access.
   assign stall       = w_start | w_access;
   assign cache_req   = w_access;
   assign cache_we    = w_access & in_mem_write;
   assign cache_addr  = w_access ? {in_alu_result[ADDR_W-1:2], 2'b00} : '0;
   assign cache_be    = w_access ? w_be : 4'b0000;
   assign cache_wdata = w_access ? w_wdata : '0;
   assign mem_error   = r_err;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start)
                  r_state <= ACCESS;
               else if (w_mem_op)
                  r_err <= 1'b1;
            end
            ACCESS: begin
               if (cache_ack) begin
                  r_rdata <= in_mem_write ? word_bytes_t'('0) : cache_rdata;
                  r_cnt   <= '0;
                  r_state <= DONE;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
                  r_cnt   <= '0;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // MEM/WB register; a misaligned word access retires with its write suppressed.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         wb_valid          <= 1'b0;
         wb_is_LB_SB       <= 1'b0;
         wb_mem_to_reg     <= 1'b0;
         wb_reg_write      <= 1'b0;
         wb_cache_data_out <= '0;
         wb_mem_block      <= 2'b00;
         wb_jump           <= 2'b00;
         wb_pc             <= '0;
         wb_alu_result     <= '0;
         wb_dest_reg       <= '0;
      end else if (w_wb_load) begin
         wb_valid          <= in_valid | (r_state == DONE);
         wb_is_LB_SB       <= in_is_LB_SB;
         wb_mem_to_reg     <= in_mem_to_reg;
         wb_reg_write      <= in_reg_write & ~((r_state == IDLE) & w_mem_op);
         wb_cache_data_out <= (r_state == DONE) ? r_rdata : word_bytes_t'('0);
         wb_mem_block      <= in_alu_result[1:0];
         wb_jump           <= in_jump;
         wb_pc             <= in_pc;
         wb_alu_result     <= in_alu_result;
         wb_dest_reg       <= in_dest_reg;
      end else if (w_start) begin
         wb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores with varied ack
// latency, misalignment, timeout and reset during an access.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        in_valid, in_mem_read, in_mem_write, in_is_LB_SB;
   logic [31:0] in_alu_result, in_store_data, in_pc;
   logic        in_mem_to_reg, in_reg_write;
   logic [1:0]  in_jump;
   logic [4:0]  in_dest_reg;
   logic        stall, cache_req, cache_we, cache_ack;
   logic [31:0] cache_addr;
   logic [0:3]  cache_be;
   word_bytes_t cache_wdata, cache_rdata, wb_cache_data_out;
   logic        wb_valid, wb_is_LB_SB, wb_mem_to_reg, wb_reg_write, mem_error;
   logic [1:0]  wb_mem_block, wb_jump;
   logic [31:0] wb_pc, wb_alu_result;
   logic [4:0]  wb_dest_reg;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
      .clk(clk), .rst_b(rst_b),
      .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_is_LB_SB(in_is_LB_SB), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_jump(in_jump),
      .in_pc(in_pc), .in_dest_reg(in_dest_reg),
      .stall(stall), .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
      .cache_be(cache_be), .cache_wdata(cache_wdata), .cache_ack(cache_ack),
      .cache_rdata(cache_rdata),
      .wb_valid(wb_valid), .wb_is_LB_SB(wb_is_LB_SB), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_reg_write(wb_reg_write), .wb_cache_data_out(wb_cache_data_out),
      .wb_mem_block(wb_mem_block), .wb_jump(wb_jump), .wb_pc(wb_pc),
      .wb_alu_result(wb_alu_result), .wb_dest_reg(wb_dest_reg), .mem_error(mem_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_is_LB_SB = 0;
      in_alu_result = 0; in_store_data = 0; in_pc = 0; in_mem_to_reg = 0;
      in_reg_write = 0; in_jump = 0; in_dest_reg = 0;
   endtask

   initial begin
      clear_in();
      cache_ack = 0; cache_rdata = '0; rst_b = 0;
      tick(); tick();
      chk("rst_stall", stall, 0);
      chk("rst_req", cache_req, 0);
      chk("rst_addr", cache_addr, 0);
      chk("rst_be", cache_be, 0);
      chk("rst_wdata", cache_wdata, 0);
      chk("rst_we", cache_we, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_alu", wb_alu_result, 0);
      chk("rst_err", mem_error, 0);
      rst_b = 1;

      // ALU op
      in_valid = 1; in_alu_result = 32'h1234; in_pc = 32'h40; in_dest_reg = 5;
      in_reg_write = 1; in_jump = JUMP_LINK;
      #1 chk("alu_stall", stall, 0);
      tick();
      chk("alu_wb_alu", wb_alu_result, 32'h1234);
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_req", cache_req, 0);
      chk("alu_stall2", stall, 0);
      chk("alu_wb_pc", wb_pc, 32'h40);
      chk("alu_wb_jump", wb_jump, 2'b10);
      chk("alu_wb_dest", wb_dest_reg, 5);
      chk("alu_wb_data", wb_cache_data_out, 0);

      // LW 0x100, ack on first ACCESS cycle
      clear_in();
      in_valid = 1; in_mem_read = 1; in_alu_result = 32'h100; in_mem_to_reg = 1; in_reg_write = 1;
      #1 chk("lw_idle_stall", stall, 1);
      chk("lw_idle_req", cache_req, 0);
      tick();
      chk("lw_req", cache_req, 1);
      chk("lw_stall", stall, 1);
      chk("lw_addr", cache_addr, 32'h100);
      chk("lw_be", cache_be, 4'b1111);
      chk("lw_we", cache_we, 0);
      chk("lw_bubble", wb_valid, 0);
      cache_ack = 1; cache_rdata = 32'hDEADBEEF;
      tick();
      cache_ack = 0; cache_rdata = '0;
      chk("lw_done_stall", stall, 0);
      chk("lw_done_req", cache_req, 0);
      tick();
      chk("lw_wb_valid", wb_valid, 1);
      chk("lw_wb_data", wb_cache_data_out, 32'hDEADBEEF);
      chk("lw_wb_blk", wb_mem_block, 0);
      chk("lw_wb_alu", wb_alu_result, 32'h100);

      // SB 0x203, ack on third ACCESS cycle
      clear_in();
      in_valid = 1; in_mem_write = 1; in_is_LB_SB = 1; in_alu_result = 32'h203;
      in_store_data = 32'h0000_00A5;
      #1 chk("sb_stall0", stall, 1);
      tick();
      chk("sb_addr", cache_addr, 32'h200);
      chk("sb_be", cache_be, 4'b0001);
      chk("sb_wdata", cache_wdata, 32'h0000_00A5);
      chk("sb_we", cache_we, 1);
      chk("sb_stall1", stall, 1);
      tick();
      chk("sb_stall2", stall, 1);
      tick();
      chk("sb_stall3", stall, 1);
      chk("sb_hold_addr", cache_addr, 32'h200);
      cache_ack = 1; cache_rdata = 32'h11111111;
      tick();
      cache_ack = 0; cache_rdata = '0;
      chk("sb_done_stall", stall, 0);
      tick();
      chk("sb_wb_blk", wb_mem_block, 3);
      chk("sb_wb_valid", wb_valid, 1);
      chk("sb_wb_data", wb_cache_data_out, 0);
      chk("sb_err", mem_error, 0);

      // SW 0x300, immediate ack
      clear_in();
      in_valid = 1; in_mem_write = 1; in_alu_result = 32'h300; in_store_data = 32'h11223344;
      tick();
      chk("sw_be", cache_be, 4'b1111);
      chk("sw_wdata", cache_wdata, 32'h11223344);
      cache_ack = 1;
      tick();
      cache_ack = 0;
      tick();
      chk("sw_wb_valid", wb_valid, 1);

      // Load timeout with TIMEOUT_CYCLES=4
      clear_in();
      in_valid = 1; in_mem_read = 1; in_alu_result = 32'h400; cache_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_req", cache_req, 1);
         chk("to_err_low", mem_error, 0);
      end
      tick();
      chk("to_err", mem_error, 1);
      chk("to_done_stall", stall, 0);
      tick();
      chk("to_wb_valid", wb_valid, 1);
      chk("to_wb_data", wb_cache_data_out, 0);
      cache_rdata = '0;

      // clear sticky error, then misaligned LW
      clear_in(); rst_b = 0;
      tick();
      rst_b = 1;
      chk("clr_err", mem_error, 0);
      in_valid = 1; in_mem_read = 1; in_alu_result = 32'h102; in_reg_write = 1;
      #1 chk("mis_stall", stall, 0);
      chk("mis_req", cache_req, 0);
      tick();
      chk("mis_err", mem_error, 1);
      chk("mis_wb_rw", wb_reg_write, 0);
      chk("mis_wb_valid", wb_valid, 1);
      chk("mis_wb_blk", wb_mem_block, 2);
      chk("mis_req2", cache_req, 0);

      // Reset during ACCESS, then a late ack
      clear_in();
      in_valid = 1; in_mem_read = 1; in_alu_result = 32'h500;
      tick();
      chk("ra_req", cache_req, 1);
      clear_in(); rst_b = 0;
      tick();
      rst_b = 1; cache_ack = 1; cache_rdata = 32'h12345678;
      tick();
      cache_ack = 0; cache_rdata = '0;
      chk("ra_req0", cache_req, 0);
      chk("ra_stall", stall, 0);
      chk("ra_err", mem_error, 0);
      chk("ra_wb_valid", wb_valid, 0);
      chk("ra_wb_data", wb_cache_data_out, 0);
      tick();
      chk("ra_idle", cache_req, 0);
      chk("ra_wb_data2", wb_cache_data_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX/MEM and the write-back stage.
- Issues one cache request per load/store and steers store bytes for byte (LB/SB) and word (LW/SW) accesses.
- Stalls the upstream pipeline until the cache acknowledges.
- Registers all MEM/WB fields, raw 4-byte cache read data and byte offset included; write-back does final byte select and sign extension.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in ACCESS awaiting cache_ack before error abort.
- ADDR_W, 32: address/data width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_b  in  1  reset, synchronous, active-low.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- in_is_LB_SB  in  1  byte access (1) vs word (0).
- in_alu_result  in  32  effective address / ALU result.
- in_store_data  in  32  rt value for stores.
- in_mem_to_reg, in_reg_write  in  1 each  control passthrough.
- in_jump  in  2  jump code; 2'b10 = link.
- in_pc  in  32  instruction PC.
- in_dest_reg  in  5  destination register.
- stall  out  1  hold EX/MEM and earlier stages.
- cache_req  out  1  access request.
- cache_we  out  1  write request.
- cache_addr  out  32  word-aligned address; bits [1:0] = 0.
- cache_be  out  4  byte enables; bit k ↔ cache byte k.
- cache_wdata  out  8x[0:3]  write bytes; byte 0 = MSB.
- cache_ack  in  1  access complete; read data valid this cycle.
- cache_rdata  in  8x[0:3]  read bytes; byte 0 = MSB.
- wb_valid, wb_is_LB_SB, wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB register.
- wb_cache_data_out  out  8x[0:3]  captured read bytes.
- wb_mem_block  out  2  address bits [1:0].
- wb_jump  out  2  passthrough.
- wb_pc, wb_alu_result  out  32 each  passthrough.
- wb_dest_reg  out  5  passthrough.
- mem_error  out  1  sticky; misalignment or timeout.

Behaviour:
- Reset (rst_b=0 at posedge):
  - State IDLE; timeout counter 0; mem_error 0.
  - All wb_* and cache_* outputs 0.
  - Reset mid-ACCESS aborts silently; a late cache_ack after reset is ignored.
- "mem op" = in_valid & (in_mem_read | in_mem_write). Read and write both set is illegal; treat as write.
- IDLE:
  - No mem op: stall=0. MEM/WB loads in_* at the edge; wb_cache_data_out = 0; wb_valid = in_valid.
  - Word mem op with alu[1:0] != 0: no cache access. Set mem_error. Load MEM/WB with wb_valid=1, wb_reg_write=0, data 0. stall=0.
  - Otherwise: stall=1 combinationally; go ACCESS; wb_valid<=0 (bubble).
- ACCESS:
  - cache_req=1, stall=1. Drive cache_addr = {alu[31:2], 2'b00} and cache_we = in_mem_write.
  - Word store: be=1111, wdata[0..3] = store[31:24]..store[7:0].
  - Byte store: be one-hot at lane alu[1:0]; that lane = store[7:0]; other lanes 0.
  - Loads: be=1111.
  - Requests stay stable until ack.
  - On cache_ack: capture cache_rdata (loads only; stores capture 0); go DONE.
  - Counter increments each cycle without ack. At TIMEOUT_CYCLES-1 without ack: set mem_error, capture 0, go DONE.
- DONE:
  - stall=0; cache_req=0.
  - MEM/WB loads in_* plus captured data; wb_valid=1; go IDLE.
  - Counter cleared.
- Latency: mem op with immediate ack = 3 cycles (IDLE, ACCESS, DONE). Non-memory op = 1 cycle.
- wb_mem_block = alu[1:0] for every instruction.

Decomposition:
- mem_stage_pkg:
  - byte_t (8-bit) and word_bytes_t ([0:3] of byte_t).
  - mem_state_e {IDLE, ACCESS, DONE}.
  - JUMP_LINK = 2'b10.
  - TIMEOUT counter width derived via $clog2.
- Sub-module mem_byte_lane: combinational store steering. Inputs is_byte, offset, store_data, is_write. Outputs be, wdata.

Test Plan:
- ALU op, in_valid=1, mem_read=mem_write=0, alu=0x0000_1234 → stall never asserted; next edge wb_alu_result=0x1234, wb_valid=1, cache_req=0.
- LW alu=0x100, ack on first ACCESS cycle, rdata={DE,AD,BE,EF} → stall high 2 cycles; cache_addr=0x100, be=1111; wb_cache_data_out={DE,AD,BE,EF}, wb_mem_block=0.
- SB alu=0x203, store_data=0x0000_00A5, ack after 3 cycles → cache_addr=0x200, be=0001, wdata={00,00,00,A5}, we=1; stall held 4 cycles; wb_mem_block=3.
- LW alu=0x102 → no cache_req; mem_error=1; wb_reg_write=0; stall=0.
- Load with ack never sent, TIMEOUT_CYCLES=4 → mem_error rises after 4 ACCESS cycles; DONE; wb_cache_data_out all 0.
- rst_b low during ACCESS, then ack pulse → state IDLE; all outputs 0; ack ignored; mem_error=0.
